// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the RV32I run/step/halt sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } run_state_t;

    localparam logic [31:0] INSN_SELF_JAL = 32'h0000006F;
    localparam logic [31:0] INSN_EBREAK   = 32'h00100073;

    // A self-jump or ebreak parks the core: it is detected but never committed.
    function automatic logic is_stop_insn(input logic [31:0] insn);
        return (insn == INSN_SELF_JAL) || (insn == INSN_EBREAK);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-control / core-status bundle between the sequencer and its surroundings.
interface cpu_run_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    import cpu_ctrl_pkg::*;

    logic                  trigger;
    logic                  step;
    logic                  halt_req;
    logic [DATA_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic [CNT_WIDTH-1:0]  limit;
    logic                  cpu_en;
    run_state_t            state;
    logic                  halted;
    logic [DATA_WIDTH-1:0] halt_pc;
    logic [CNT_WIDTH-1:0]  instr_count;

    modport master (
        output trigger, step, halt_req, pc, instr, limit,
        input  cpu_en, state, halted, halt_pc, instr_count
    );

    modport slave (
        input  trigger, step, halt_req, pc, instr, limit,
        output cpu_en, state, halted, halt_pc, instr_count
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous control input, plus an edge flop.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: gates core commits via cpu_en and counts retired instructions.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0] async_w;
    logic [2:0] level_w;
    logic [2:0] rise_w;

    assign async_w = {bus.halt_req, bus.step, bus.trigger};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge u_sync (
                .clk   (clk),
                .rst   (rst),
                .din   (async_w[gi]),
                .level (level_w[gi]),
                .rise  (rise_w[gi])
            );
        end
    endgenerate

    logic trig_rise, step_rise, halt_lvl;
    logic unused_sync;
    assign trig_rise   = rise_w[0];
    assign step_rise   = rise_w[1];
    assign halt_lvl    = level_w[2];
    assign unused_sync = ^{level_w[1:0], rise_w[2]};

    run_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] halt_pc_q, halt_pc_d;
    logic [CNT_WIDTH-1:0]  cnt_plus1;
    logic                  stop_insn, limit_hit, cpu_en, clr_cnt;

    assign stop_insn = is_stop_insn(bus.instr);
    assign cnt_plus1 = count_q + CNT_ONE;
    // The +1 wraps to zero at saturation, so a nonzero limit can never match there.
    assign limit_hit = (bus.limit != '0) && (cnt_plus1 == bus.limit);
    assign cpu_en    = ((state_q == RUN) || (state_q == STEP)) && !stop_insn && !halt_lvl;

    always_comb begin
        state_d = state_q;
        clr_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_rise)      state_d = RUN;
                else if (step_rise) state_d = STEP;
            end
            RUN: begin
                if (halt_lvl)       state_d = IDLE;
                else if (stop_insn) state_d = HALT;
                else if (limit_hit) state_d = HALT;
            end
            STEP: begin
                if (halt_lvl)       state_d = IDLE;
                else if (stop_insn) state_d = HALT;
                else if (limit_hit) state_d = HALT;
                else                state_d = IDLE;
            end
            HALT: begin
                if (trig_rise) begin
                    state_d = IDLE;
                    clr_cnt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (clr_cnt)
            count_d = '0;
        else if (cpu_en && (count_q != '1))
            count_d = cnt_plus1;
    end

    assign halt_pc_d = ((state_d == HALT) && (state_q != HALT)) ? bus.pc : halt_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    assign bus.cpu_en      = cpu_en;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.halt_pc     = halt_pc_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny fetch model (PC += 4 on each commit).
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    localparam logic [31:0] ALU = 32'h00108093;

    logic clk = 1'b0;
    logic rst;
    logic core_clr;
    logic [31:0] core_pc;
    logic [31:0] imem [0:63];
    int commits = 0;
    int base;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();

    cpu_run_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst)               core_pc <= '0;
        else if (core_clr)      core_pc <= '0;
        else if (bus.cpu_en)    core_pc <= core_pc + 32'd4;
    end

    always @(posedge clk) begin
        if (rst && bus.cpu_en) commits <= commits + 1;
    end

    assign bus.pc    = core_pc;
    assign bus.instr = imem[core_pc[7:2]];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input run_state_t exp, input int max_cyc, input string tag);
        int n = 0;
        while (bus.state !== exp && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.state), 64'(exp));
    endtask

    task automatic pulse_trigger();
        bus.trigger = 1'b1;
        ticks(3);
        bus.trigger = 1'b0;
    endtask

    task automatic clear_pc();
        core_clr = 1'b1;
        tick();
        core_clr = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ticks(2);
    endtask

    initial begin
        rst = 1'b0;
        core_clr = 1'b0;
        bus.trigger = 1'b0;
        bus.step = 1'b0;
        bus.halt_req = 1'b0;
        bus.limit = '0;
        for (int i = 0; i < 64; i++) imem[i] = ALU;
        ticks(2);
        check("rst_state", 64'(bus.state), 64'(IDLE));
        check("rst_cpu_en", 64'(bus.cpu_en), 64'd0);
        check("rst_halted", 64'(bus.halted), 64'd0);
        check("rst_halt_pc", 64'(bus.halt_pc), 64'd0);
        check("rst_count", 64'(bus.instr_count), 64'd0);
        rst = 1'b1;
        ticks(2);

        // Run 5 ALU ops into a self-jump
        imem[5] = INSN_SELF_JAL;
        bus.trigger = 1'b1;
        ticks(2);
        check("trig_lat_idle", 64'(bus.state), 64'(IDLE));
        tick();
        check("trig_lat_run", 64'(bus.state), 64'(RUN));
        check("trig_lat_en", 64'(bus.cpu_en), 64'd1);
        bus.trigger = 1'b0;
        base = commits;
        wait_state(HALT, 40, "run_to_halt");
        check("run_commits", 64'(commits - base), 64'd5);
        check("run_count", 64'(bus.instr_count), 64'd5);
        check("run_halt_pc", 64'(bus.halt_pc), 64'h14);
        check("run_halted", 64'(bus.halted), 64'd1);
        check("run_en_off", 64'(bus.cpu_en), 64'd0);
        ticks(4);
        check("halt_hold_en", 64'(bus.cpu_en), 64'd0);
        check("halt_hold_commits", 64'(commits - base), 64'd5);

        // Leave HALT, then single-step three times
        pulse_trigger();
        check("halt_exit_state", 64'(bus.state), 64'(IDLE));
        check("halt_exit_count", 64'(bus.instr_count), 64'd0);
        imem[5] = ALU;
        clear_pc();
        for (int i = 1; i <= 3; i++) begin
            base = commits;
            bus.step = 1'b1;
            ticks(2);
            check($sformatf("step%0d_lat_idle", i), 64'(bus.state), 64'(IDLE));
            tick();
            check($sformatf("step%0d_state", i), 64'(bus.state), 64'(STEP));
            check($sformatf("step%0d_en", i), 64'(bus.cpu_en), 64'd1);
            tick();
            check($sformatf("step%0d_back_idle", i), 64'(bus.state), 64'(IDLE));
            check($sformatf("step%0d_en_off", i), 64'(bus.cpu_en), 64'd0);
            bus.step = 1'b0;
            ticks(10);
            check($sformatf("step%0d_count", i), 64'(bus.instr_count), 64'(i));
            check($sformatf("step%0d_commits", i), 64'(commits - base), 64'd1);
        end

        // Instruction limit of 4
        reset_pulse();
        check("lim_rst_count", 64'(bus.instr_count), 64'd0);
        bus.limit = 32'd4;
        pulse_trigger();
        check("lim_run", 64'(bus.state), 64'(RUN));
        base = commits;
        wait_state(HALT, 40, "lim_to_halt");
        check("lim_commits", 64'(commits - base), 64'd4);
        check("lim_count", 64'(bus.instr_count), 64'd4);
        check("lim_halted", 64'(bus.halted), 64'd1);
        check("lim_halt_pc", 64'(bus.halt_pc), 64'hC);
        pulse_trigger();
        check("lim_exit_state", 64'(bus.state), 64'(IDLE));
        check("lim_exit_count", 64'(bus.instr_count), 64'd0);
        bus.limit = '0;

        // Pause with halt_req mid-RUN, then resume
        clear_pc();
        pulse_trigger();
        check("hr_run", 64'(bus.state), 64'(RUN));
        ticks(3);
        check("hr_pre_count", 64'(bus.instr_count), 64'd3);
        bus.halt_req = 1'b1;
        tick();
        check("hr_k_en", 64'(bus.cpu_en), 64'd1);
        tick();
        check("hr_k1_en", 64'(bus.cpu_en), 64'd0);
        check("hr_k1_state", 64'(bus.state), 64'(RUN));
        tick();
        check("hr_k2_state", 64'(bus.state), 64'(IDLE));
        check("hr_count", 64'(bus.instr_count), 64'd5);
        bus.halt_req = 1'b0;
        ticks(4);
        check("hr_idle_count", 64'(bus.instr_count), 64'd5);
        pulse_trigger();
        check("hr_resume", 64'(bus.state), 64'(RUN));
        ticks(2);
        check("hr_resume_count", 64'(bus.instr_count), 64'd7);
        bus.halt_req = 1'b1;
        ticks(3);
        check("hr2_state", 64'(bus.state), 64'(IDLE));
        check("hr2_count", 64'(bus.instr_count), 64'd9);
        bus.halt_req = 1'b0;
        ticks(4);

        // Simultaneous trigger and step rises; step ignored in HALT
        reset_pulse();
        imem[2] = INSN_SELF_JAL;
        bus.trigger = 1'b1;
        bus.step = 1'b1;
        ticks(3);
        check("both_run", 64'(bus.state), 64'(RUN));
        bus.trigger = 1'b0;
        bus.step = 1'b0;
        wait_state(HALT, 20, "both_to_halt");
        check("both_count", 64'(bus.instr_count), 64'd2);
        check("both_halt_pc", 64'(bus.halt_pc), 64'h8);
        bus.step = 1'b1;
        ticks(4);
        bus.step = 1'b0;
        ticks(4);
        check("halt_step_state", 64'(bus.state), 64'(HALT));
        check("halt_step_count", 64'(bus.instr_count), 64'd2);
        check("halt_step_en", 64'(bus.cpu_en), 64'd0);

        // Asynchronous reset in the middle of RUN
        pulse_trigger();
        check("ar_idle", 64'(bus.state), 64'(IDLE));
        imem[2] = ALU;
        clear_pc();
        pulse_trigger();
        ticks(3);
        check("ar_pre_count", 64'(bus.instr_count), 64'd3);
        check("ar_pre_halt_pc", 64'(bus.halt_pc), 64'h8);
        #2;
        rst = 1'b0;
        #1;
        check("ar_state", 64'(bus.state), 64'(IDLE));
        check("ar_en", 64'(bus.cpu_en), 64'd0);
        check("ar_halted", 64'(bus.halted), 64'd0);
        check("ar_halt_pc", 64'(bus.halt_pc), 64'd0);
        check("ar_count", 64'(bus.instr_count), 64'd0);
        tick();
        rst = 1'b1;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt sequencer for the single-cycle RV32I core. It sits between the board-level controls (trigger, step, halt) and the core. It emits one execute-enable, `cpu_en`, which gates the PC register, register-file write and data-memory write. It also counts retired instructions and stops the core on a halt instruction, an instruction limit, or an external halt request.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `pc` and `instr`.
- `CNT_WIDTH`, 32, width of the retired-instruction counter and `limit`.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low (asserted at 0).
- `trigger` input, 1 bit: start/resume request. Asynchronous; the rising edge is used.
- `step` input, 1 bit: single-step request. Asynchronous; the rising edge is used.
- `halt_req` input, 1 bit: pause request. Asynchronous; level-sensitive.
- `pc` input, `DATA_WIDTH` bits: current PC from the fetch stage (status only).
- `instr` input, 32 bits: current fetched instruction (combinational from instruction memory).
- `limit` input, `CNT_WIDTH` bits: stop after this many retired instructions. 0 means unlimited.
- `cpu_en` output, 1 bit: the core commits the current instruction this cycle.
- `state` output, 2 bits: 0 = IDLE, 1 = RUN, 2 = STEP, 3 = HALT.
- `halted` output, 1 bit: high when `state` is HALT.
- `halt_pc` output, `DATA_WIDTH` bits: PC captured on entry to HALT.
- `instr_count` output, `CNT_WIDTH` bits: retired-instruction count.

## Operation
- Synchronisers:
  - `trigger`, `step` and `halt_req` each pass through 2 flops, then a third flop for edge detection.
  - Rise pulse is s2 & !s3. The `halt_req` level is s2.
- `stop_insn` is high when `instr` equals 32'h0000006F (`jal x0,0`) or 32'h00100073 (`ebreak`).
- `cpu_en` is combinational: (state is RUN or STEP) and not `stop_insn` and not synced `halt_req`. A stop instruction is therefore never executed, and the PC holds on it.
- State transitions (priority follows the listed order within each state):
  - IDLE:
    - trigger rise → RUN.
    - else step rise → STEP.
    - Simultaneous rises: trigger wins.
  - RUN:
    - synced `halt_req` → IDLE (pause, resumable).
    - else `stop_insn` → HALT.
    - else `limit`≠0 and `instr_count`+1 == `limit` → HALT. That final instruction commits.
    - else stay in RUN.
  - STEP:
    - synced `halt_req` → IDLE.
    - else `stop_insn` → HALT.
    - else → IDLE after exactly one cycle with `cpu_en`=1. The limit check applies as in RUN and wins over IDLE.
  - HALT:
    - trigger rise → IDLE, and `instr_count` is cleared.
    - step rises are ignored.
- `instr_count`:
  - Increments by 1 on each edge where `cpu_en`=1.
  - Saturates at all-ones and never wraps.
  - The limit compare uses a `CNT_WIDTH`-bit +1 with no carry-out.
- `halt_pc` loads `pc` on the edge that enters HALT. It holds otherwise.
- An edge pulse that arrives in a state that does not use it is dropped, not queued.

## Timing
- Reset (`rst`=0), asynchronous:
  - `state`=IDLE, `cpu_en`=0, `halted`=0, `halt_pc`=0, `instr_count`=0.
  - All synchroniser flops are 0.
- Reset mid-RUN: outputs go to their reset values immediately. Any in-flight pulse is lost.
- Trigger latency: `trigger` first sampled high at edge k → `state`=RUN after edge k+2 → `cpu_en` high in the following cycle. The same latency applies to `step`.
- `halt_req` latency: first sampled high at edge k → `cpu_en` low from edge k+1 (combinational on s2). `state`=IDLE after edge k+2.
- Stop detection: `cpu_en` drops in the same cycle the stop instruction is presented. `state`=HALT after that edge.
- STEP: exactly one commit per accepted step rise, provided no stop instruction or halt request intervenes.

## Structure
- Package `cpu_ctrl_pkg`:
  - `run_state_t` enum (IDLE, RUN, STEP, HALT).
  - Constants `INSN_SELF_JAL` = 32'h0000006F and `INSN_EBREAK` = 32'h00100073.
- Sub-module `sync_edge`: 2-flop synchroniser plus edge flop, with outputs `level` and `rise`. Instantiated three times.
- The top-level core instantiates `cpu_run_ctrl` and ANDs `cpu_en` into the PC, regfile and data-memory enables.

## Test plan
- Reset, then pulse `trigger` with `limit`=0 and a program of 5 ALU ops followed by `jal x0,0` → RUN, exactly 5 commits, `instr_count`=5, HALT, `halt_pc`=0x14, `cpu_en`=0 thereafter.
- From IDLE, pulse `step` 3 times with 10+ cycles between pulses → 3 single-cycle `cpu_en` pulses, `instr_count`=3, `state` returns to IDLE after each.
- Set `limit`=4 and run a long ALU loop → exactly 4 commits, HALT, `halted`=1. A `trigger` rise then gives IDLE with `instr_count`=0.
- Raise `halt_req` mid-RUN → `cpu_en` low 2 edges after first sample, then IDLE. A later `trigger` resumes RUN and the count continues.
- Assert `trigger` and `step` rising at the same edge in IDLE → RUN; pulse `step` in HALT → no change.
- Drop `rst` low mid-RUN with an asynchronous edge → all outputs go to reset values before the next `clk` edge.
